instr_fifo: RTL and testbench

Parametrised single-clock instruction FIFO with valid/ready handshakes on both sides, replacing the fixed 64×64 instruction buffer between the external interface and the controller. It stores up to DEPTH words of DATA_W bits, presents the head word show-ahead to the controller, and reports occupancy and threshold flags. It also supports a synchronous flush used by the controller on pipeline restart.

---
 rtl/instr_fifo_if.sv | 20 ++
 rtl/instr_fifo.sv | 99 +++++++++
 tb/tb_instr_fifo.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fifo_if.sv
// rtl/instr_fifo_if.sv - valid/ready word stream bundle for the instruction FIFO
//
// Purpose: one direction of a valid/ready handshake carrying DATA_W-bit words.
// Signals:
//   data  - word being offered
//   valid - data holds a word this cycle
//   ready - receiver accepts the word at the next rising edge
// Modports:
//   master - producer side (drives data/valid, samples ready)
//   slave  - consumer side (samples data/valid, drives ready)
interface instr_fifo_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - parametrised single-clock show-ahead instruction FIFO
//
// Purpose: buffers up to DEPTH instruction words between the external
// interface and the controller, presenting the head word show-ahead.
// Optional feature macro: INSTR_FIFO_ERR_EN adds the sticky overflow_err port.
// Ports:
//   clk          - single clock, all state changes on the rising edge
//   rst          - asynchronous active-high reset (pointers, count, error flag)
//   flush        - synchronous discard of every stored word
//   in_if        - slave stream from the external interface (in_ready = !full)
//   out_if       - master stream to the controller (out_valid = count != 0)
//   count        - occupancy 0..DEPTH
//   almost_full  - count >= AFULL_TH
//   almost_empty - count <= AEMPTY_TH
//   overflow_err - sticky write-while-full flag (INSTR_FIFO_ERR_EN only)
module instr_fifo #(
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 64,
  parameter int AFULL_TH  = DEPTH - 4,
  parameter int AEMPTY_TH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  instr_fifo_if.slave              in_if,
  instr_fifo_if.master             out_if,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
`ifdef INSTR_FIFO_ERR_EN
  output logic                     almost_empty,
  output logic                     overflow_err
`else
  output logic                     almost_empty
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push;
  logic              pop;

  // Every status output decodes only the registered count, so neither
  // in_valid nor out_ready has a combinational path to an output.
  assign in_if.ready  = (count != DEPTH_C);
  assign out_if.valid = (count != '0);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);

  assign push = in_if.valid & in_if.ready;
  assign pop  = out_if.valid & out_if.ready;

  // Head word straight from storage; no bypass of in_data when empty.
  assign out_if.data = mem[rd_ptr];

  // Pointers wrap by natural ADDR_W-bit overflow (DEPTH is a power of two).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage is never reset or cleared; flush only rewinds the pointers.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= in_if.data;
  end

`ifdef INSTR_FIFO_ERR_EN
  // Flush wins over a write attempt against a full FIFO in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      overflow_err <= 1'b0;
    else if (flush)
      overflow_err <= 1'b0;
    else if (in_if.valid && !in_if.ready)
      overflow_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_instr_fifo.sv
// tb/tb_instr_fifo.sv - self-checking bench for instr_fifo against a queue model
module tb_instr_fifo;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 4;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [CW-1:0] count;
  logic          almost_full;
  logic          almost_empty;
`ifdef INSTR_FIFO_ERR_EN
  logic          overflow_err;
`endif

  instr_fifo_if #(.DATA_W(DW)) in_if ();
  instr_fifo_if #(.DATA_W(DW)) out_if ();

  instr_fifo #(
    .DATA_W(DW), .DEPTH(DEPTH), .AFULL_TH(AF), .AEMPTY_TH(AE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_if(in_if),
    .out_if(out_if),
    .count(count),
    .almost_full(almost_full),
`ifdef INSTR_FIFO_ERR_EN
    .almost_empty(almost_empty),
    .overflow_err(overflow_err)
`else
    .almost_empty(almost_empty)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] q[$];
  bit            ovf_m;
  int            n_cmp = 0;
  int            n_err = 0;

  // Expected {in_ready, out_valid, almost_full, almost_empty} from model occupancy.
  function automatic logic [3:0] exp_flags();
    return {q.size() < DEPTH, q.size() != 0, q.size() >= AF, q.size() <= AE};
  endfunction

  function automatic logic [3:0] obs_flags();
    return {in_if.ready, out_if.valid, almost_full, almost_empty};
  endfunction

  // One clock of stimulus; model follows the FIFO rules on queue length.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit r, input bit f);
    bit do_push;
    bit do_pop;
    in_if.valid = v;
    in_if.data = d;
    out_if.ready = r;
    flush = f;
    do_push = v && (q.size() < DEPTH);
    do_pop = r && (q.size() > 0);
    @(posedge clk);
    #1;
    if (f) begin
      q.delete();
      ovf_m = 1'b0;
    end else begin
      if (v && q.size() == DEPTH) ovf_m = 1'b1;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(d);
    end
    in_if.valid = 1'b0;
    out_if.ready = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    in_if.valid = 1'b0;
    in_if.data = '0;
    out_if.ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_flags() !== 4'b1001) begin
      n_err++; $display("FAIL reset_flags got=%b exp=%b", obs_flags(), 4'b1001);
    end
    n_cmp++;
    if (count !== 4'd0) begin
      n_err++; $display("FAIL reset_count got=%0d exp=0", count);
    end
`ifdef INSTR_FIFO_ERR_EN
    n_cmp++;
    if (overflow_err !== 1'b0) begin
      n_err++; $display("FAIL reset_ovf got=%b exp=0", overflow_err);
    end
`endif
    rst = 1'b0;
    q.delete();
    ovf_m = 1'b0;
  endtask

  task automatic test_fill_order();
    for (int k = 1; k <= 3; k++) step(1'b1, DW'(k), 1'b0, 1'b0);
    n_cmp++;
    if (count !== 4'd3) begin
      n_err++; $display("FAIL fill3_count got=%0d exp=3", count);
    end
    n_cmp++;
    if (obs_flags() !== 4'b1101) begin
      n_err++; $display("FAIL fill3_flags got=%b exp=1101", obs_flags());
    end
    n_cmp++;
    if (out_if.data !== 32'd1) begin
      n_err++; $display("FAIL fill3_head got=%0h exp=1", out_if.data);
    end
    for (int k = 4; k <= 8; k++) begin
      step(1'b1, DW'(k), 1'b0, 1'b0);
      n_cmp++;
      if ({in_if.ready, almost_full} !== {k < 8, k >= 6}) begin
        n_err++;
        $display("FAIL fill_flags at %0d got ir/af=%b%b exp=%b%b", k,
                 in_if.ready, almost_full, k < 8, k >= 6);
      end
    end
    step(1'b1, 32'd9, 1'b0, 1'b0);
    n_cmp++;
    if (count !== 4'd8) begin
      n_err++; $display("FAIL overpush_count got=%0d exp=8", count);
    end
`ifdef INSTR_FIFO_ERR_EN
    n_cmp++;
    if (overflow_err !== 1'b1) begin
      n_err++; $display("FAIL overpush_ovf got=%b exp=1", overflow_err);
    end
`endif
    for (int k = 1; k <= 8; k++) begin
      n_cmp++;
      if (out_if.valid !== 1'b1 || out_if.data !== DW'(k)) begin
        n_err++;
        $display("FAIL drain_order got v=%b d=%0h exp v=1 d=%0h", out_if.valid, out_if.data, k);
      end
      step(1'b0, '0, 1'b1, 1'b0);
    end
    n_cmp++;
    if (count !== 4'd0 || out_if.valid !== 1'b0) begin
      n_err++; $display("FAIL drained got count=%0d v=%b exp 0/0", count, out_if.valid);
    end
  endtask

  task automatic test_full_push_pop();
    logic [DW-1:0] d;
    for (int k = 0; k < DEPTH; k++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    d = DW'($urandom);
    step(1'b1, d, 1'b1, 1'b0);
    n_cmp++;
    if (count !== 4'd7) begin
      n_err++; $display("FAIL full_pushpop_count got=%0d exp=7", count);
    end
    n_cmp++;
    if (out_if.data !== q[0]) begin
      n_err++; $display("FAIL full_pushpop_head got=%0h exp=%0h", out_if.data, q[0]);
    end
    step(1'b1, d, 1'b0, 1'b0);
    n_cmp++;
    if (count !== 4'd8 || in_if.ready !== 1'b0) begin
      n_err++; $display("FAIL refill got count=%0d ir=%b exp 8/0", count, in_if.ready);
    end
    while (q.size() > 0) begin
      n_cmp++;
      if (out_if.data !== q[0]) begin
        n_err++; $display("FAIL full_drain got=%0h exp=%0h", out_if.data, q[0]);
      end
      step(1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 32'd100, 1'b0, 1'b0);
    step(1'b1, 32'd101, 1'b0, 1'b0);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      step(1'b1, DW'(102 + i), 1'b1, 1'b0);
      n_cmp++;
      if (count !== 4'd2 || out_if.data !== DW'(101 + i)) begin
        n_err++;
        $display("FAIL stream i=%0d got count=%0d d=%0h exp count=2 d=%0h",
                 i, count, out_if.data, 101 + i);
      end
    end
  endtask

  task automatic test_flush();
    while (q.size() < DEPTH) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    step(1'b1, 32'hdead, 1'b0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    n_cmp++;
    if (count !== 4'd5) begin
      n_err++; $display("FAIL preflush_count got=%0d exp=5", count);
    end
    step(1'b1, 32'haa, 1'b0, 1'b1);
    n_cmp++;
    if (count !== 4'd0 || out_if.valid !== 1'b0) begin
      n_err++; $display("FAIL flush got count=%0d v=%b exp 0/0", count, out_if.valid);
    end
`ifdef INSTR_FIFO_ERR_EN
    n_cmp++;
    if (overflow_err !== 1'b0) begin
      n_err++; $display("FAIL flush_ovf got=%b exp=0", overflow_err);
    end
`endif
    step(1'b1, 32'h55, 1'b0, 1'b0);
    n_cmp++;
    if (count !== 4'd1 || out_if.valid !== 1'b1 || out_if.data !== 32'h55) begin
      n_err++;
      $display("FAIL postflush got count=%0d v=%b d=%0h exp 1/1/55", count, out_if.valid, out_if.data);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
           $urandom_range(0, 49) == 0);
      n_cmp++;
      if (count !== CW'(q.size()) || obs_flags() !== exp_flags()) begin
        n_err++;
        $display("FAIL rand_state i=%0d got count=%0d flags=%b exp count=%0d flags=%b",
                 i, count, obs_flags(), q.size(), exp_flags());
      end
      if (q.size() > 0) begin
        n_cmp++;
        if (out_if.data !== q[0]) begin
          n_err++; $display("FAIL rand_head i=%0d got=%0h exp=%0h", i, out_if.data, q[0]);
        end
      end
`ifdef INSTR_FIFO_ERR_EN
      n_cmp++;
      if (overflow_err !== ovf_m) begin
        n_err++; $display("FAIL rand_ovf i=%0d got=%b exp=%b", i, overflow_err, ovf_m);
      end
`endif
    end
  endtask

  task automatic test_async_reset();
    step(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    n_cmp++;
    if (count !== 4'd4) begin
      n_err++; $display("FAIL prerst_count got=%0d exp=4", count);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (count !== 4'd0 || out_if.valid !== 1'b0 || in_if.ready !== 1'b1) begin
      n_err++;
      $display("FAIL async_rst got count=%0d v=%b ir=%b exp 0/0/1", count, out_if.valid, in_if.ready);
    end
    q.delete();
    ovf_m = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_order();
    test_full_push_pop();
    test_back_to_back();
    test_flush();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
